// File: rtl/csr_regfile.sv
// Control/status register file: serves CSR reads and masked writes, and commits exception/ertn side effects.
// It also runs the stable timer and produces the aggregated interrupt request.
module csr_regfile #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  input  logic [31:0] coreid_in,
  output logic [31:0] csr_eentry,
  output logic [31:0] csr_era,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] TCFG_MASK = 32'((64'd1 << TIMER_W) - 64'd1);

  logic [1:0]         plv_q, plv_d, pplv_q, pplv_d;
  logic               ie_q, ie_d, da_q, da_d, ppie_q, ppie_d;
  logic [12:0]        lie_q, lie_d, is_q, is_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esub_q, esub_d;
  logic [31:0]        era_q, era_d, badv_q, badv_d, tid_q, tid_d;
  logic [25:0]        eentry_q, eentry_d;
  logic [3:0][31:0]   save_q, save_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d;

  logic [31:0] crmd_v, prmd_v, ecfg_v, estat_v, tcfg_v, tval_v, eentry_v;
  logic [31:0] crmd_w, prmd_w, ecfg_w, estat_w, era_w, badv_w, eentry_w, tid_w, tcfg_w;
  logic [3:0][31:0] save_w;
  logic        timer_fire, ticlr_hit;

  function automatic logic [31:0] mergeW(input logic [31:0] old, input logic [31:0] writable,
                                         input logic [31:0] wval, input logic [31:0] wmask);
    logic [31:0] m;
    m = wmask & writable;
    return (old & ~m) | (wval & m);
  endfunction

  assign crmd_v   = {28'b0, da_q, ie_q, plv_q};
  assign prmd_v   = {29'b0, ppie_q, pplv_q};
  assign ecfg_v   = {19'b0, lie_q};
  assign estat_v  = {1'b0, esub_q, ecode_q, 3'b0, is_q};
  assign eentry_v = {eentry_q, 6'b0};
  assign tcfg_v   = 32'(tcfg_q);
  assign tval_v   = 32'(tval_q);

  assign crmd_w   = mergeW(crmd_v,   32'h0000_000F, csr_wvalue, csr_wmask);
  assign prmd_w   = mergeW(prmd_v,   32'h0000_0007, csr_wvalue, csr_wmask);
  assign ecfg_w   = mergeW(ecfg_v,   32'h0000_1BFF, csr_wvalue, csr_wmask);
  assign estat_w  = mergeW(estat_v,  32'h0000_0003, csr_wvalue, csr_wmask);
  assign era_w    = mergeW(era_q,    32'hFFFF_FFFF, csr_wvalue, csr_wmask);
  assign badv_w   = mergeW(badv_q,   32'hFFFF_FFFF, csr_wvalue, csr_wmask);
  assign eentry_w = mergeW(eentry_v, 32'hFFFF_FFC0, csr_wvalue, csr_wmask);
  assign tid_w    = mergeW(tid_q,    32'hFFFF_FFFF, csr_wvalue, csr_wmask);
  assign tcfg_w   = mergeW(tcfg_v,   TCFG_MASK,     csr_wvalue, csr_wmask);

  for (genvar g = 0; g < 4; g++) begin : g_save
    assign save_w[g] = mergeW(save_q[g], 32'hFFFF_FFFF, csr_wvalue, csr_wmask);
  end

  // A TCFG write reloads the counter and suppresses expiry on that edge.
  assign timer_fire = !(csr_we && csr_num == CSR_TCFG) && tcfg_q[0] && (tval_q == '0);
  assign ticlr_hit  = csr_we && csr_num == CSR_TICLR && csr_wvalue[0] && csr_wmask[0];

  always_comb begin
    csr_rvalue = 32'b0;
    if (csr_re) begin
      case (csr_num)
        CSR_CRMD:   csr_rvalue = crmd_v;
        CSR_PRMD:   csr_rvalue = prmd_v;
        CSR_ECFG:   csr_rvalue = ecfg_v;
        CSR_ESTAT:  csr_rvalue = estat_v;
        CSR_ERA:    csr_rvalue = era_q;
        CSR_BADV:   csr_rvalue = badv_q;
        CSR_EENTRY: csr_rvalue = eentry_v;
        CSR_SAVE0:  csr_rvalue = save_q[0];
        CSR_SAVE1:  csr_rvalue = save_q[1];
        CSR_SAVE2:  csr_rvalue = save_q[2];
        CSR_SAVE3:  csr_rvalue = save_q[3];
        CSR_TID:    csr_rvalue = tid_q;
        CSR_TCFG:   csr_rvalue = tcfg_v;
        CSR_TVAL:   csr_rvalue = tval_v;
        default:    csr_rvalue = 32'b0;
      endcase
    end
  end

  // Software writes first, then ertn, then exception commit override the fields they own.
  always_comb begin
    plv_d = plv_q; ie_d = ie_q; da_d = da_q;
    pplv_d = pplv_q; ppie_d = ppie_q;
    lie_d = lie_q; is_d = is_q; ecode_d = ecode_q; esub_d = esub_q;
    era_d = era_q; badv_d = badv_q; eentry_d = eentry_q;
    save_d = save_q; tid_d = tid_q; tcfg_d = tcfg_q; tval_d = tval_q;

    if (csr_we) begin
      case (csr_num)
        CSR_CRMD:   begin plv_d = crmd_w[1:0]; ie_d = crmd_w[2]; da_d = crmd_w[3]; end
        CSR_PRMD:   begin pplv_d = prmd_w[1:0]; ppie_d = prmd_w[2]; end
        CSR_ECFG:   lie_d = ecfg_w[12:0];
        CSR_ESTAT:  is_d[1:0] = estat_w[1:0];
        CSR_ERA:    era_d = era_w;
        CSR_BADV:   badv_d = badv_w;
        CSR_EENTRY: eentry_d = eentry_w[31:6];
        CSR_SAVE0:  save_d[0] = save_w[0];
        CSR_SAVE1:  save_d[1] = save_w[1];
        CSR_SAVE2:  save_d[2] = save_w[2];
        CSR_SAVE3:  save_d[3] = save_w[3];
        CSR_TID:    tid_d = tid_w;
        CSR_TCFG:   begin
          tcfg_d = tcfg_w[TIMER_W-1:0];
          tval_d = {tcfg_w[TIMER_W-1:2], 2'b00};
        end
        default: ;
      endcase
    end

    if (ertn_flush) begin
      plv_d = pplv_q;
      ie_d  = ppie_q;
    end

    if (wb_ex) begin
      pplv_d  = plv_q;
      ppie_d  = ie_q;
      plv_d   = 2'b0;
      ie_d    = 1'b0;
      ecode_d = wb_ecode;
      esub_d  = wb_esubcode;
      era_d   = wb_pc;
      if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv_d = wb_vaddr;
    end

    if (!(csr_we && csr_num == CSR_TCFG) && tcfg_q[0]) begin
      if (tval_q != '0) tval_d = tval_q - 1'b1;
      else if (tcfg_q[1]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      else tcfg_d[0] = 1'b0;
    end

    is_d[9:2] = hw_int_in;
    is_d[10]  = 1'b0;
    is_d[12]  = ipi_int_in;
    if (ticlr_hit) is_d[11] = 1'b0;
    if (timer_fire) is_d[11] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      plv_q <= 2'b0; ie_q <= 1'b0; da_q <= 1'b1;
      pplv_q <= 2'b0; ppie_q <= 1'b0;
      lie_q <= '0; is_q <= '0; ecode_q <= '0; esub_q <= '0;
      era_q <= '0; badv_q <= '0; eentry_q <= '0;
      save_q <= '0; tid_q <= coreid_in; tcfg_q <= '0; tval_q <= '0;
    end else begin
      plv_q <= plv_d; ie_q <= ie_d; da_q <= da_d;
      pplv_q <= pplv_d; ppie_q <= ppie_d;
      lie_q <= lie_d; is_q <= is_d; ecode_q <= ecode_d; esub_q <= esub_d;
      era_q <= era_d; badv_q <= badv_d; eentry_q <= eentry_d;
      save_q <= save_d; tid_q <= tid_d; tcfg_q <= tcfg_d; tval_q <= tval_d;
    end
  end

  assign csr_eentry = eentry_v;
  assign csr_era    = era_q;
  assign has_int    = ie_q && |(is_q & lie_q);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: a table of single-cycle read/write vectors
// followed by hand-written exception, interrupt, timer and reset sequences.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] coreid_in;
  logic [31:0] csr_eentry, csr_era;
  logic        has_int;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct packed {
    logic        re;
    logic [13:0] num;
    logic        we;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  csr_regfile #(.TIMER_W(32)) dut (
    .clk(clk), .reset(reset),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .coreid_in(coreid_in),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drive, check the combinational read, let the next rising edge commit.
  task automatic applyStimulus(input vec_t v, input int idx);
    csr_re = v.re; csr_num = v.num; csr_we = v.we;
    csr_wmask = v.wmask; csr_wvalue = v.wvalue;
    #1;
    checkOutput($sformatf("vec%0d", idx), csr_rvalue, v.exp);
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic csrWrite(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [13:0] num, input logic [31:0] expected);
    csr_re = 1'b1; csr_num = num;
    #1;
    checkOutput(name, csr_rvalue, expected);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 14'h000, 1'b0, 32'h0, 32'h0, 32'h0000_0008};
    vecs[1]  = '{1'b1, 14'h040, 1'b0, 32'h0, 32'h0, 32'hC0DE_0001};
    vecs[2]  = '{1'b1, 14'h123, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 14'h000, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 14'h030, 1'b1, 32'hFFFF_FFFF, 32'h1111_2222, 32'h0};
    vecs[5]  = '{1'b1, 14'h030, 1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h1111_2222};
    vecs[6]  = '{1'b1, 14'h030, 1'b0, 32'h0, 32'h0, 32'hDEAD_2222};
    vecs[7]  = '{1'b1, 14'h004, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b1, 14'h004, 1'b0, 32'h0, 32'h0, 32'h0000_1BFF};
    vecs[9]  = '{1'b1, 14'h005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b1, 14'h005, 1'b0, 32'h0, 32'h0, 32'h0000_0003};
    vecs[11] = '{1'b1, 14'h005, 1'b1, 32'h0000_0003, 32'h0, 32'h0000_0003};
    vecs[12] = '{1'b1, 14'h042, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b1, 14'h042, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[14] = '{1'b1, 14'h00C, 1'b1, 32'hFFFF_FFFF, 32'h1C00_0FFF, 32'h0};
    vecs[15] = '{1'b1, 14'h00C, 1'b0, 32'h0, 32'h0, 32'h1C00_0FC0};
    vecs[16] = '{1'b1, 14'h044, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vecs[17] = '{1'b1, 14'h123, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vecs[18] = '{1'b1, 14'h000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0008};
    vecs[19] = '{1'b1, 14'h000, 1'b0, 32'h0, 32'h0, 32'h0000_000F};
    vecs[20] = '{1'b1, 14'h001, 1'b0, 32'h0, 32'h0, 32'h0};

    reset = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0;
    csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0;
    wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0; ertn_flush = 1'b0;
    hw_int_in = '0; ipi_int_in = 1'b0; coreid_in = 32'hC0DE_0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    checkOutput("rst_eentry", csr_eentry, 32'h0);
    checkOutput("rst_era", csr_era, 32'h0);
    checkOutput("rst_has_int", {31'b0, has_int}, 32'h0);

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);
    checkOutput("eentry_out", csr_eentry, 32'h1C00_0FC0);

    // Exception with a same-cycle CRMD write that must be dropped; ALE records BADV.
    csr_we = 1'b1; csr_num = 14'h000; csr_wmask = 32'h7; csr_wvalue = 32'h0;
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h3;
    @(negedge clk);
    csr_we = 1'b0; wb_ex = 1'b0;
    readCheck("ex_crmd", 14'h000, 32'h0000_0008);
    readCheck("ex_prmd", 14'h001, 32'h0000_0007);
    readCheck("ex_estat", 14'h005, 32'h0009_0000);
    readCheck("ex_era", 14'h006, 32'h1C00_0100);
    readCheck("ex_badv", 14'h007, 32'h0000_0003);
    checkOutput("ex_era_out", csr_era, 32'h1C00_0100);
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    readCheck("ertn_crmd", 14'h000, 32'h0000_000F);

    // Non-address exception leaves BADV alone.
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h1; wb_pc = 32'h0000_2000; wb_vaddr = 32'h55;
    @(negedge clk);
    wb_ex = 1'b0;
    readCheck("ex2_badv", 14'h007, 32'h0000_0003);
    readCheck("ex2_estat", 14'h005, 32'h004B_0000);
    readCheck("ex2_crmd", 14'h000, 32'h0000_0008);
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    readCheck("ertn2_crmd", 14'h000, 32'h0000_000F);

    // Hardware interrupt lines sample into IS[9:2]; LIE is still 0x1BFF.
    hw_int_in = 8'hA5;
    @(negedge clk);
    readCheck("hwint_estat", 14'h005, 32'h004B_0294);
    checkOutput("hwint_has_int", {31'b0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    @(negedge clk);
    checkOutput("hwint_clear", {31'b0, has_int}, 32'h0);

    // Periodic timer.
    csrWrite(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
    csrWrite(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
    readCheck("tval_load", 14'h042, 32'h8);
    idle(8);
    readCheck("tval_zero", 14'h042, 32'h0);
    readCheck("is11_pre", 14'h005, 32'h004B_0000);
    checkOutput("has_int_pre", {31'b0, has_int}, 32'h0);
    idle(1);
    readCheck("is11_set", 14'h005, 32'h004B_0800);
    readCheck("tval_reload", 14'h042, 32'h8);
    checkOutput("has_int_timer", {31'b0, has_int}, 32'h1);
    csrWrite(14'h000, 32'h4, 32'h0);
    checkOutput("has_int_ie0", {31'b0, has_int}, 32'h0);
    csrWrite(14'h044, 32'hFFFF_FFFF, 32'h1);
    readCheck("ticlr", 14'h005, 32'h004B_0000);

    // One-shot timer clears En on expiry and never wraps.
    csrWrite(14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
    idle(9);
    readCheck("oneshot_tcfg", 14'h041, 32'h8);
    readCheck("oneshot_is11", 14'h005, 32'h004B_0800);
    idle(1);
    readCheck("oneshot_tval", 14'h042, 32'h0);

    // Timer expiry on the same edge as a TICLR write keeps IS[11] set.
    csrWrite(14'h044, 32'hFFFF_FFFF, 32'h1);
    csrWrite(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
    idle(8);
    readCheck("race_pre", 14'h005, 32'h004B_0000);
    csrWrite(14'h044, 32'hFFFF_FFFF, 32'h1);
    readCheck("race_set_wins", 14'h005, 32'h004B_0800);

    // One-cycle reset in the middle of a countdown.
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    readCheck("rst_tval", 14'h042, 32'h0);
    readCheck("rst_tcfg", 14'h041, 32'h0);
    readCheck("rst_estat", 14'h005, 32'h0);
    readCheck("rst_crmd", 14'h000, 32'h8);
    readCheck("rst_tid", 14'h040, 32'hC0DE_0001);
    checkOutput("rst2_has_int", {31'b0, has_int}, 32'h0);
    checkOutput("rst2_era", csr_era, 32'h0);
    checkOutput("rst2_eentry", csr_eentry, 32'h0);
    @(negedge clk);
    readCheck("rst_tval_hold", 14'h042, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file: the responder to WB-stage CSR requests.
- Serves csrrd/csrwr/csrxchg reads and masked writes.
- Commits exception and ertn side effects; runs the stable timer; aggregates interrupts.
- Drives exception entry and return addresses back to the fetch redirect logic.

Parameters:
TIMER_W, 32, width of TVAL and of the TCFG initial-value field incl. low 2 zero bits

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets state on next edge)
csr_re  input  1  read enable
csr_num  input  14  CSR address for read and write
csr_rvalue  output  32  read data, combinational
csr_we  input  1  write enable
csr_wmask  input  32  per-bit write mask
csr_wvalue  input  32  write data
wb_ex  input  1  exception commit (valid-qualified by WB)
wb_ecode  input  6  exception code
wb_esubcode  input  9  exception subcode
wb_pc  input  32  PC of excepting instruction
wb_vaddr  input  32  faulting address
ertn_flush  input  1  ertn commit
hw_int_in  input  8  hardware interrupt lines, level
ipi_int_in  input  1  inter-processor interrupt, level
coreid_in  input  32  core id loaded into TID at reset
csr_eentry  output  32  exception entry {EENTRY[31:6],6'b0}
csr_era  output  32  ERA value for ertn redirect
has_int  output  1  interrupt pending and enabled

Behaviour:
- Register map:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3]
  - PRMD 0x1: PPLV[1:0], PPIE[2]
  - ECFG 0x4: LIE[12:0], bit 10 always 0
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]
  - ERA 0x6, BADV 0x7
  - EENTRY 0xC: VA[31:6]
  - SAVE0-3 0x30-0x33
  - TID 0x40
  - TCFG 0x41: En[0], Periodic[1], InitVal[TIMER_W-1:2]
  - TVAL 0x42: read-only
  - TICLR 0x44: reads 0
- Unimplemented/reserved bits read 0 and ignore writes.
- Read: csr_rvalue = csr_re ? reg(csr_num) : 0. Unmapped csr_num reads 0. Zero latency.
- Write: on the edge with csr_we, reg <= (reg & ~wmask) | (wvalue & wmask), writable fields only. Writable fields:
  - ESTAT: IS[1:0] only.
  - TVAL: none.
  - Unmapped address: no effect.
- Reset values:
  - CRMD=0x8 (PLV0, IE0, DA1).
  - TID=coreid_in.
  - All other registers 0, including TCFG.En=0.
  - Outputs after reset: csr_rvalue=0 when csr_re=0, csr_eentry=0, csr_era=0, has_int=0.
- Reset mid-operation wins over every other event, including a pending timer or exception.
- Same-cycle priority for CRMD/PRMD/ESTAT/ERA/BADV: wb_ex > ertn_flush > csr_we. The lower-priority update is dropped for the fields the higher one touches.
- wb_ex commit:
  - PRMD.PPLV<=CRMD.PLV, PRMD.PPIE<=CRMD.IE; then CRMD.PLV<=0, CRMD.IE<=0.
  - ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode.
  - ERA<=wb_pc.
  - BADV<=wb_vaddr only when wb_ecode is 0x08 (ADEF) or 0x09 (ALE).
- ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PPIE.
- Interrupt sampling, every cycle: ESTAT.IS[9:2]<=hw_int_in, IS[12]<=ipi_int_in.
- Timer:
  - TCFG write loads TVAL<={InitVal,2'b00} on the same edge.
  - Otherwise, if En and TVAL!=0: TVAL<=TVAL-1.
  - If En and TVAL==0: IS[11]<=1. If Periodic, TVAL reloads {InitVal,2'b00}; else TCFG.En<=0 (one-shot).
  - TVAL wraps never.
- TICLR write with effective bit0=1 clears IS[11]. A same-cycle timer set wins over the clear.
- has_int = CRMD.IE && |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Combinational from registered state.

Test Plan:
- Release reset, csr_re=1, csr_num=0x0 -> csr_rvalue=0x00000008. csr_num=0x40 -> coreid_in value. csr_num=0x123 -> 0.
- csr_we, num=0x30, wvalue=0xDEADBEEF, wmask=0xFFFF0000, over SAVE0=0x11112222 -> next read 0xDEAD2222.
- Setup: CRMD.PLV=3, IE=1. Apply wb_ex with ecode=0x09, subcode=0, pc=0x1C000100, vaddr=0x00000003, plus csr_we to CRMD in the same cycle.
  - Result: CRMD=0x8, PRMD=0x7, ESTAT[21:16]=0x09, ERA=0x1C000100, BADV=0x3.
  - Then ertn_flush -> CRMD.PLV=3, IE=1.
- Timer: write TCFG=0x0000000B (InitVal=2, periodic, En) -> TVAL=8.
  - IS[11] sets 9 cycles later; TVAL reloads 8.
  - TICLR write 1 -> IS[11]=0.
  - Non-periodic 0x9 -> TCFG.En reads 0 after expiry.
- Set ECFG.LIE=0x800, CRMD.IE=1, hw_int_in=0 and run the timer -> has_int=1 on expiry. Then CRMD.IE=0 -> has_int=0.
- Assert reset for 1 cycle mid-countdown -> TVAL=0, TCFG=0, ESTAT=0, has_int=0 next cycle.
